// File: rtl/mc_control_decode.sv
// mc_control_decode: multicycle control/decode stage in front of the register file.
// Takes one MIPS-style instruction from fetch. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. The stage runs ADD/SUB/AND/OR/SLT,
// ADDI, LW and SW, and flags any other encoding as illegal.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   instr_in/instr_valid  instruction from fetch; accepted only in FETCH
//   instr_ready, pc_inc   FETCH indicator; one-cycle pulse after each accept
//   rs, rt / op_a, op_b   register-file read indices and the data read back
//   rd, wb_data, reg_we   register-file write port; rd is 0 outside WB
//   mem_req/we/addr/wdata data-memory request; held until mem_ready
//   mem_rdata, mem_ready  load data and completion from memory
//   illegal               one-cycle pulse in DECODE on an unsupported encoding
//   dbg_state_o           current FSM state (0 FETCH .. 4 WB) for checkers
//
// Handshake: fetch presents instr_in with instr_valid. The transfer happens on
// the clock edge where instr_valid && instr_ready. Memory sees one request per
// load or store. mem_req stays high until the edge where mem_ready is sampled,
// and mem_ready is ignored in any other state.
module mc_control_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        pc_inc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] wb_data,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        illegal,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q;     // instruction register
  logic [31:0] alu_q;    // ALUOut
  logic [31:0] mdr_q;    // load data
  logic [31:0] wdata_q;  // store data captured in EXEC

  // Field decode of the held instruction
  logic [5:0]  opcode, funct;
  logic [31:0] imm_sx;
  logic        is_r, is_addi, is_lw, is_sw, legal;
  logic [4:0]  dest;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    is_r    = 1'b0;
    is_addi = (opcode == 6'h08);
    is_lw   = (opcode == 6'h23);
    is_sw   = (opcode == 6'h2B);
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: is_r = 1'b1;
        default:                           is_r = 1'b0;
      endcase
    end
    legal = is_r | is_addi | is_lw | is_sw;
    dest  = is_r ? ir_q[15:11] : ir_q[20:16];
  end

  // ALU: R-type uses op_b, the immediate forms use the sign-extended imm
  logic [31:0] alu_b, alu_res;
  assign alu_b = is_r ? op_b : imm_sx;

  always_comb begin
    alu_res = op_a + alu_b;
    if (is_r) begin
      case (funct)
        6'h22:   alu_res = op_a - alu_b;
        6'h24:   alu_res = op_a & alu_b;
        6'h25:   alu_res = op_a | alu_b;
        6'h2A:   alu_res = {31'b0, ($signed(op_a) < $signed(alu_b))};
        default: alu_res = op_a + alu_b;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q    <= 32'h0;
      alu_q   <= 32'h0;
      mdr_q   <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      if (state_q == S_FETCH && instr_valid) ir_q <= instr_in;
      if (state_q == S_EXEC) begin
        alu_q   <= alu_res;
        wdata_q <= op_b;
      end
      if (state_q == S_MEM && mem_ready && is_lw) mdr_q <= mem_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_FETCH;
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs decode only registered state and registers. instr_ready is also
  // gated by rst so that it reads 0 while reset is held.
  always_comb begin
    instr_ready = 1'b0;
    pc_inc      = 1'b0;
    rs          = 5'd0;
    rt          = 5'd0;
    rd          = 5'd0;
    wb_data     = 32'h0;
    reg_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    illegal     = 1'b0;
    if (state_q != S_FETCH) begin
      rs = ir_q[25:21];
      rt = ir_q[20:16];
    end
    case (state_q)
      S_FETCH:  instr_ready = rst;
      S_DECODE: begin
        pc_inc  = 1'b1;
        illegal = ~legal;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = alu_q;
        mem_wdata = wdata_q;
      end
      S_WB: begin
        // Register 0 as destination: no write is issued and rd stays 0
        rd      = dest;
        reg_we  = (dest != 5'd0);
        wb_data = is_lw ? mdr_q : alu_q;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_control_decode.sv
// Testbench for mc_control_decode. It holds a small register-file array that
// answers the DUT's rs/rt reads, plus a memory responder with a programmable
// wait. An instruction-level model predicts the result of each instruction.
module tb_mc_control_decode;

  logic        clk, rst;
  logic [31:0] instr_in;
  logic        instr_valid, instr_ready, pc_inc;
  logic [4:0]  rs, rt, rd;
  logic [31:0] op_a, op_b, wb_data;
  logic        reg_we, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, illegal;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [32];
  assign op_a = rf[rs];
  assign op_b = rf[rt];

  mc_control_decode dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_inc(pc_inc), .rs(rs), .rt(rt), .rd(rd),
    .op_a(op_a), .op_b(op_b), .wb_data(wb_data), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          total;      // instruction cycles including the accept cycle; -1 on timeout
    int          wb_cycle;
    int          we_cnt;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          rd_stray;   // cycles with rd != 0 and no write strobe
    int          mem_cycles;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] mwdata;
    int          ill_cnt;
    int          ill_cycle;
    int          pc_cnt;
    logic        ready_at_start;
  } obs_t;

  typedef struct {
    bit          legal;
    bit          is_mem;
    bit          is_st;
    bit          writes;
    logic [4:0]  dest;
    logic [31:0] val;
    logic [31:0] addr;
    int          total;
  } exp_t;

  // Instruction-level reference model
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] rdata,
                                 input int wt);
    exp_t e;
    logic [5:0]  op, fn;
    logic [31:0] imm;
    op  = ins[31:26];
    fn  = ins[5:0];
    imm = {{16{ins[15]}}, ins[15:0]};
    e = '{legal: 1'b1, is_mem: 1'b0, is_st: 1'b0, writes: 1'b0,
          dest: 5'd0, val: 32'h0, addr: 32'h0, total: 4};
    case (op)
      6'h00: begin
        e.dest = ins[15:11];
        case (fn)
          6'h20: e.val = a + b;
          6'h22: e.val = a - b;
          6'h24: e.val = a & b;
          6'h25: e.val = a | b;
          6'h2A: e.val = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          default: e.legal = 1'b0;
        endcase
      end
      6'h08: begin e.dest = ins[20:16]; e.val = a + imm; end
      6'h23: begin e.dest = ins[20:16]; e.val = rdata; e.addr = a + imm;
                   e.is_mem = 1'b1; e.total = 5 + wt; end
      6'h2B: begin e.addr = a + imm; e.is_mem = 1'b1; e.is_st = 1'b1;
                   e.total = 4 + wt; end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) begin
      e.total = 2; e.dest = 5'd0; e.is_mem = 1'b0; e.is_st = 1'b0;
    end
    e.writes = e.legal && !e.is_st && (e.dest != 5'd0);
    return e;
  endfunction

  // Driver and monitor for one instruction. Call it at a negedge while the
  // DUT is in FETCH. It returns once instr_ready shows again, or on timeout.
  task automatic exec(input logic [31:0] ins, input int wt, input logic [31:0] rdata,
                      input bit noise, input bit hold, output obs_t o);
    int cyc, m;
    bit done;
    o = '{total: -1, wb_cycle: 0, we_cnt: 0, wb_rd: 5'd0, wb_data: 32'h0,
          rd_stray: 0, mem_cycles: 0, maddr: 32'h0, mwe: 1'b0, mwdata: 32'h0,
          ill_cnt: 0, ill_cycle: 0, pc_cnt: 0, ready_at_start: instr_ready};
    instr_in    = ins;
    instr_valid = 1'b1;
    mem_rdata   = rdata;
    mem_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc = 1; m = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!hold) instr_valid = 1'b0;
      if (noise) instr_in = $urandom;
      if (pc_inc) o.pc_cnt++;
      if (illegal) begin o.ill_cnt++; o.ill_cycle = cyc; end
      if (reg_we) begin
        o.we_cnt++; o.wb_cycle = cyc; o.wb_rd = rd; o.wb_data = wb_data;
      end else if (rd != 5'd0) o.rd_stray++;
      if (mem_req) begin
        if (o.mem_cycles == 0) begin
          o.maddr = mem_addr; o.mwe = mem_we; o.mwdata = mem_wdata;
        end
        o.mem_cycles++;
        mem_ready = (m == wt);
        m++;
      end else begin
        mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (instr_ready) begin done = 1; o.total = cyc - 1; end
    end
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic test_reset();
    rst = 1'b0; instr_valid = 1'b0; instr_in = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low got=%b exp=0", instr_ready); end
    checks++; if ({pc_inc, reg_we, mem_req, mem_we, illegal} !== 5'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0", {pc_inc, reg_we, mem_req, mem_we, illegal}); end
    checks++; if ({rs, rt, rd} !== 15'b0 || wb_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_buses rs/rt/rd=%h wb=%h addr=%h exp=0", {rs, rt, rd}, wb_data, mem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", instr_ready); end
    @(negedge clk);
  endtask

  task automatic test_add();
    obs_t o;
    rf[1] = 32'd5; rf[2] = 32'd7;
    exec(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.ready_at_start !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", o.ready_at_start); end
    checks++; if (o.wb_cycle != 4 || o.wb_rd !== 5'd3 || o.wb_data !== 32'd12 || o.we_cnt != 1) begin failures++; $display("FAIL add_wb cyc=%0d rd=%0d data=%h we=%0d exp cyc=4 rd=3 data=c we=1", o.wb_cycle, o.wb_rd, o.wb_data, o.we_cnt); end
    checks++; if (o.total != 4 || o.rd_stray != 0 || o.pc_cnt != 1) begin failures++; $display("FAIL add_timing total=%0d stray=%0d pc=%0d exp 4/0/1", o.total, o.rd_stray, o.pc_cnt); end
  endtask

  task automatic test_sub_slt();
    obs_t o;
    rf[1] = 32'd0; rf[2] = 32'd1;
    exec(r_ins(5'd1, 5'd2, 5'd4, 6'h22), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.wb_rd !== 5'd4 || o.wb_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wrap rd=%0d data=%h exp rd=4 data=ffffffff", o.wb_rd, o.wb_data); end
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd1;
    exec(r_ins(5'd1, 5'd2, 5'd6, 6'h2A), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.wb_rd !== 5'd6 || o.wb_data !== 32'd1) begin failures++; $display("FAIL slt_signed rd=%0d data=%h exp rd=6 data=1", o.wb_rd, o.wb_data); end
    exec(r_ins(5'd2, 5'd1, 5'd6, 6'h2A), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.wb_data !== 32'd0) begin failures++; $display("FAIL slt_false data=%h exp=0", o.wb_data); end
  endtask

  task automatic test_lw();
    obs_t o;
    rf[1] = 32'h100;
    exec(i_ins(6'h23, 5'd1, 5'd5, 16'hFFFC), 2, 32'hDEAD_BEEF, 1'b0, 1'b0, o);
    checks++; if (o.maddr !== 32'hFC || o.mwe !== 1'b0 || o.mem_cycles != 3) begin failures++; $display("FAIL lw_mem addr=%h we=%b cycles=%0d exp fc/0/3", o.maddr, o.mwe, o.mem_cycles); end
    checks++; if (o.wb_rd !== 5'd5 || o.wb_data !== 32'hDEAD_BEEF || o.we_cnt != 1 || o.wb_cycle != 7) begin failures++; $display("FAIL lw_wb rd=%0d data=%h we=%0d cyc=%0d exp 5/deadbeef/1/7", o.wb_rd, o.wb_data, o.we_cnt, o.wb_cycle); end
    checks++; if (o.total != 7) begin failures++; $display("FAIL lw_total got=%0d exp=7", o.total); end
  endtask

  task automatic test_sw();
    obs_t o;
    rf[1] = 32'h20; rf[2] = 32'h55;
    exec(i_ins(6'h2B, 5'd1, 5'd2, 16'd8), 1, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.maddr !== 32'h28 || o.mwdata !== 32'h55 || o.mwe !== 1'b1) begin failures++; $display("FAIL sw_mem addr=%h wdata=%h we=%b exp 28/55/1", o.maddr, o.mwdata, o.mwe); end
    checks++; if (o.we_cnt != 0 || o.total != 5 || o.mem_cycles != 2) begin failures++; $display("FAIL sw_seq we=%0d total=%0d mem=%0d exp 0/5/2", o.we_cnt, o.total, o.mem_cycles); end
  endtask

  task automatic test_illegal();
    obs_t o;
    exec(i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.ill_cnt != 1 || o.ill_cycle != 2 || o.total != 2 || o.we_cnt != 0 || o.mem_cycles != 0) begin failures++; $display("FAIL ill_opcode cnt=%0d cyc=%0d total=%0d we=%0d mem=%0d exp 1/2/2/0/0", o.ill_cnt, o.ill_cycle, o.total, o.we_cnt, o.mem_cycles); end
    exec(r_ins(5'd1, 5'd2, 5'd3, 6'h01), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.ill_cnt != 1 || o.total != 2 || o.we_cnt != 0 || o.mem_cycles != 0) begin failures++; $display("FAIL ill_funct cnt=%0d total=%0d we=%0d mem=%0d exp 1/2/0/0", o.ill_cnt, o.total, o.we_cnt, o.mem_cycles); end
  endtask

  task automatic test_addi_r0();
    obs_t o;
    rf[1] = 32'd3;
    exec(i_ins(6'h08, 5'd1, 5'd0, 16'd9), 0, 32'h0, 1'b0, 1'b0, o);
    checks++; if (o.we_cnt != 0 || o.rd_stray != 0 || o.total != 4 || o.ill_cnt != 0) begin failures++; $display("FAIL addi_r0 we=%0d stray=%0d total=%0d ill=%0d exp 0/0/4/0", o.we_cnt, o.rd_stray, o.total, o.ill_cnt); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    rf[1] = 32'd10; rf[2] = 32'd20;
    exec(r_ins(5'd1, 5'd2, 5'd7, 6'h25), 0, 32'h0, 1'b1, 1'b1, o);
    checks++; if (o.pc_cnt != 1 || o.total != 4 || o.wb_data !== (32'd10 | 32'd20)) begin failures++; $display("FAIL hold_valid pc=%0d total=%0d data=%h exp 1/4/1e", o.pc_cnt, o.total, o.wb_data); end
    exec(i_ins(6'h08, 5'd2, 5'd8, 16'hFFFF), 0, 32'h0, 1'b1, 1'b1, o);
    checks++; if (o.pc_cnt != 1 || o.wb_rd !== 5'd8 || o.wb_data !== 32'd19) begin failures++; $display("FAIL b2b_addi pc=%0d rd=%0d data=%h exp 1/8/13", o.pc_cnt, o.wb_rd, o.wb_data); end
  endtask

  task automatic test_reset_mid_mem();
    int k, we_seen, req_seen;
    rf[1] = 32'h100;
    instr_in = i_ins(6'h23, 5'd1, 5'd5, 16'hFFFC);
    instr_valid = 1'b1; mem_ready = 1'b0;
    k = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    while (!mem_req && k < 10) begin @(negedge clk); k++; end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_reach_mem got=%b exp=1", mem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, reg_we, instr_ready, pc_inc, illegal} !== 6'b0 || mem_addr !== 32'h0 || {rs, rt, rd} !== 15'b0) begin failures++; $display("FAIL rstmid_outputs strobes=%b addr=%h idx=%h exp 0", {mem_req, mem_we, reg_we, instr_ready, pc_inc, illegal}, mem_addr, {rs, rt, rd}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", instr_ready); end
    we_seen = 0; req_seen = 0;
    mem_ready = 1'b1;  // must be ignored outside MEM
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (reg_we) we_seen++;
      if (mem_req) req_seen++;
    end
    mem_ready = 1'b0;
    checks++; if (we_seen != 0 || req_seen != 0 || instr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_quiet we=%0d req=%0d ready=%b exp 0/0/1", we_seen, req_seen, instr_ready); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [31:0] ins, rdata;
    logic [5:0]  fn_tab [5];
    logic [5:0]  bad_op [4];
    logic [5:0]  bad_fn [4];
    int          k, wt;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bad_op = '{6'h01, 6'h3F, 6'h0C, 6'h04};
    bad_fn = '{6'h00, 6'h21, 6'h26, 6'h3F};
    for (int n = 0; n < 60; n++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'h0;
      ins = $urandom;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: ins = r_ins(ins[25:21], ins[20:16], ins[15:11], fn_tab[k]);
        5: ins[31:26] = 6'h08;
        6: ins[31:26] = 6'h23;
        7: ins[31:26] = 6'h2B;
        8: ins[31:26] = bad_op[$urandom_range(0, 3)];
        default: ins = r_ins(ins[25:21], ins[20:16], ins[15:11], bad_fn[$urandom_range(0, 3)]);
      endcase
      wt = $urandom_range(0, 3);
      rdata = $urandom;
      e = model(ins, rf[ins[25:21]], rf[ins[20:16]], rdata, wt);
      exec(ins, wt, rdata, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
      checks++; if (o.total != e.total || o.pc_cnt != 1 || o.rd_stray != 0) begin failures++; $display("FAIL rnd_seq n=%0d ins=%h total=%0d/%0d pc=%0d stray=%0d", n, ins, o.total, e.total, o.pc_cnt, o.rd_stray); end
      checks++; if (o.ill_cnt != (e.legal ? 0 : 1)) begin failures++; $display("FAIL rnd_illegal n=%0d ins=%h got=%0d exp=%0d", n, ins, o.ill_cnt, e.legal ? 0 : 1); end
      checks++; if (o.we_cnt != (e.writes ? 1 : 0)) begin failures++; $display("FAIL rnd_we n=%0d ins=%h got=%0d exp=%0d", n, ins, o.we_cnt, e.writes ? 1 : 0); end
      if (e.writes) begin
        checks++; if (o.wb_rd !== e.dest || o.wb_data !== e.val) begin failures++; $display("FAIL rnd_wb n=%0d ins=%h rd=%0d/%0d data=%h/%h", n, ins, o.wb_rd, e.dest, o.wb_data, e.val); end
      end
      checks++; if (o.mem_cycles != (e.is_mem ? wt + 1 : 0)) begin failures++; $display("FAIL rnd_memcyc n=%0d ins=%h got=%0d exp=%0d", n, ins, o.mem_cycles, e.is_mem ? wt + 1 : 0); end
      if (e.is_mem) begin
        checks++; if (o.maddr !== e.addr || o.mwe !== e.is_st) begin failures++; $display("FAIL rnd_mem n=%0d ins=%h addr=%h/%h we=%b/%b", n, ins, o.maddr, e.addr, o.mwe, e.is_st); end
        if (e.is_st) begin
          checks++; if (o.mwdata !== rf[ins[20:16]]) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, o.mwdata, rf[ins[20:16]]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_lw();
    test_sw();
    test_illegal();
    test_addi_r0();
    test_back_to_back();
    test_reset_mid_mem();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
